// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-step multiply/divide unit that owns the HI/LO pair.
// A start/busy/done handshake lets control stall mfhi/mflo until the result lands.
// Optional feature macro: MULDIV_SIGNED_EN (op[0] selects signed MULT/DIV).
// Without the macro every operation is unsigned and no sign logic is built.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DZ   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  // Multiply: {partial upper product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits / quotient bits}.
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opnd_r;    // multiplicand or divisor magnitude
  logic               is_div_r;

  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic [WIDTH-1:0]   div_rem_s;
  logic [2*WIDTH-1:0] step_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   res_hi_s;
  logic [WIDTH-1:0]   res_lo_s;
  logic               b_zero_s;

  assign b_zero_s = (b == ZERO_W);

`ifdef MULDIV_SIGNED_EN
  logic sign_a_s;
  logic sign_b_s;
  logic neg_prod_r;   // product / quotient needs negation
  logic neg_rem_r;    // remainder takes the sign of the dividend

  // Operand magnitudes: two's-complement absolute value for signed ops.
  always_comb begin
    sign_a_s = op[0] & a[WIDTH-1];
    sign_b_s = op[0] & b[WIDTH-1];
    mag_a_s  = sign_a_s ? (ZERO_W - a) : a;
    mag_b_s  = sign_b_s ? (ZERO_W - b) : b;
  end

  // Capture sign-correction flags at the accepting edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      neg_prod_r <= 1'b0;
      neg_rem_r  <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      neg_prod_r <= sign_a_s ^ sign_b_s;
      neg_rem_r  <= sign_a_s;
    end
  end
`else
  logic unused_op_s;
  assign unused_op_s = op[0];

  // Unsigned build: operands pass through unchanged.
  always_comb begin
    mag_a_s = a;
    mag_b_s = b;
  end
`endif

  // One shift-add or restoring shift-subtract iteration on the accumulator.
  always_comb begin
    step_s      = ZERO_2W;
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = acc_r[2*WIDTH-1:WIDTH-1];
    div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
    // True difference is below the divisor when div_ge_s holds, so WIDTH bits suffice.
    div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_r;
    div_rem_s   = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
    if (is_div_r) begin
      step_s = {div_rem_s, acc_r[WIDTH-2:0], div_ge_s};
    end else begin
      step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Final result with sign correction, taken from the last iteration's output.
  always_comb begin
    prod_s = step_s;
    quot_s = step_s[WIDTH-1:0];
    rem_s  = step_s[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
    if (neg_prod_r) begin
      prod_s = ZERO_2W - step_s;
      quot_s = ZERO_W - step_s[WIDTH-1:0];
    end else begin
      prod_s = step_s;
      quot_s = step_s[WIDTH-1:0];
    end
    if (neg_rem_r) begin
      rem_s = ZERO_W - step_s[2*WIDTH-1:WIDTH];
    end else begin
      rem_s = step_s[2*WIDTH-1:WIDTH];
    end
`endif
    if (is_div_r) begin
      res_hi_s = rem_s;
      res_lo_s = quot_s;
    end else begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM with registered handshake outputs and the HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      acc_r    <= ZERO_2W;
      opnd_r   <= ZERO_W;
      is_div_r <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= ZERO_W;
      lo       <= ZERO_W;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            // start beats mthi/mtlo in the same cycle.
            cnt_r    <= CNT_ZERO;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            is_div_r <= op[1];
            if (op[1] && b_zero_s) begin
              state_r <= DZ;
              acc_r   <= {ZERO_W, a};     // raw dividend goes to HI
              opnd_r  <= ZERO_W;
            end else if (op[1]) begin
              state_r <= RUN;
              acc_r   <= {ZERO_W, mag_a_s};
              opnd_r  <= mag_b_s;
            end else begin
              state_r <= RUN;
              acc_r   <= {ZERO_W, mag_b_s};
              opnd_r  <= mag_a_s;
            end
          end else begin
            if (hi_we) begin
              hi <= wdata;
            end
            if (lo_we) begin
              lo <= wdata;
            end
          end
        end
        RUN: begin
          acc_r <= step_s;
          cnt_r <= (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
          if (cnt_r == CNT_LAST) begin
            hi      <= res_hi_s;
            lo      <= res_lo_s;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= IDLE;
          end
        end
        DZ: begin
          hi       <= acc_r[WIDTH-1:0];
          lo       <= ONES_W;
          div_zero <= 1'b1;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed, table-driven bench for muldiv_unit plus hand-written
// sequences for ignored starts, mthi/mtlo rules, contention and async reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t v [11];

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive a start request for one edge (called away from the rising edge).
  task automatic issue(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb);
    start = 1'b1; op = o; a = aa; b = bb;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count edges after acceptance until done is seen, bounded at 40.
  task automatic wait_done(input string name, output int lat);
    bit busy_ok;
    busy_ok = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_busy_run"}, 32'(busy_ok), 32'd1);
    chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;

    v[0]  = '{"multu_max",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32};
    v[1]  = '{"divu_100_7", 2'b10, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 32};
    v[3]  = '{"divu_dz",    2'b10, 32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 1};
    v[4]  = '{"multu_3_5",  2'b00, 32'd3,        32'd5,        32'h00000000, 32'h0000000F, 1'b0, 32};
    v[7]  = '{"divu_by1",   2'b10, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, 32};
    v[9]  = '{"multu_shift",2'b00, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0, 32};
    v[10] = '{"div_dz_neg", 2'b11, 32'hFFFFFF00, 32'h0,        32'hFFFFFF00, 32'hFFFFFFFF, 1'b1, 1};
`ifdef MULDIV_SIGNED_EN
    v[2]  = '{"div_m7_2",   2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32};
    v[5]  = '{"mult_m3_5",  2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 32};
    v[6]  = '{"div_min_m1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 32};
    v[8]  = '{"div_7_m2",   2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 32};
`else
    v[2]  = '{"div_m7_2",   2'b11, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 1'b0, 32};
    v[5]  = '{"mult_m3_5",  2'b01, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, 1'b0, 32};
    v[6]  = '{"div_min_m1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 32};
    v[8]  = '{"div_7_m2",   2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000007, 32'h00000000, 1'b0, 32};
`endif

    // Reset values while reset is held.
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz",   32'(div_zero), 32'd0);
    chk("rst_hi",   hi, 32'h0);
    chk("rst_lo",   lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Vector table, issued back-to-back (each start lands while done=1).
    for (int i = 0; i < 11; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      chk({v[i].name, "_busy_t0"}, 32'(busy), 32'd1);
      wait_done(v[i].name, lat);
      chk({v[i].name, "_lat"}, 32'(lat), 32'(v[i].lat));
      chk({v[i].name, "_hi"}, hi, v[i].hi);
      chk({v[i].name, "_lo"}, lo, v[i].lo);
      chk({v[i].name, "_dz"}, 32'(div_zero), 32'(v[i].dz));
    end

    // Async reset in the middle of an operation.
    issue(2'b00, 32'd2, 32'd3);
    repeat (14) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_hi",   hi, 32'h0);
    chk("mid_rst_lo",   lo, 32'h0);
    chk("mid_rst_dz",   32'(div_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(2'b00, 32'd2, 32'd3);
    wait_done("post_rst", lat);
    chk("post_rst_lat", 32'(lat), 32'd32);
    chk("post_rst_lo",  lo, 32'd6);
    chk("post_rst_hi",  hi, 32'd0);

    // Start while busy is ignored; mthi while busy is ignored; HI/LO hold in RUN.
    issue(2'b00, 32'd6, 32'd7);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      start = (lat == 10);
      op = 2'b10; a = 32'd9; b = 32'd3;
      hi_we = (lat == 15);
      wdata = 32'hA5A5A5A5;
      @(negedge clk);
      if (lat == 16) begin
        chk("busy_hi_we_ignored", hi, 32'h0);
        chk("run_lo_hold", lo, 32'd6);
      end
    end while (!done && lat < 40);
    start = 1'b0;
    hi_we = 1'b0;
    chk("ign_start_done", 32'(done), 32'd1);
    chk("ign_start_lat", 32'(lat), 32'd32);
    chk("ign_start_lo", lo, 32'd42);
    chk("ign_start_hi", hi, 32'd0);

    // mthi in IDLE.
    hi_we = 1'b1; wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1 hi_we = 1'b0;
    @(negedge clk);
    chk("mthi_hi", hi, 32'hA5A5A5A5);
    chk("mthi_lo_kept", lo, 32'd42);
    chk("mthi_no_done", 32'(done), 32'd0);

    // mthi and mtlo together.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BADF00D;
    @(posedge clk);
    #1 begin hi_we = 1'b0; lo_we = 1'b0; end
    @(negedge clk);
    chk("both_we_hi", hi, 32'h0BADF00D);
    chk("both_we_lo", lo, 32'h0BADF00D);

    // start beats simultaneous mthi/mtlo.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
    issue(2'b00, 32'd3, 32'd5);
    hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    chk("contend_hi", hi, 32'h0BADF00D);
    chk("contend_lo", lo, 32'h0BADF00D);
    chk("contend_busy", 32'(busy), 32'd1);
    wait_done("contend", lat);
    chk("contend_lat", 32'(lat), 32'd32);
    chk("contend_res_lo", lo, 32'd15);
    chk("contend_res_hi", hi, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide stage downstream of the ALU operand path.
- Owns the architectural HI/LO register pair.
- Takes a and b from register read when the decoder issues mult/div, runs 32 iterations, and holds the 64-bit result in HI/LO.
- Replaces single-cycle falling-edge mult/div with a clocked start/busy/done handshake so the control unit can stall mfhi/mflo until the result is valid.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  request a new operation; sampled only when busy=0.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  WIDTH  multiplicand / dividend.
- b  input  WIDTH  multiplier / divisor.
- hi_we  input  1  mthi: write wdata into HI; honoured only when busy=0 and start=0.
- lo_we  input  1  mtlo: write wdata into LO; same rules as hi_we.
- wdata  input  WIDTH  data for mthi/mtlo.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: HI/LO were just updated.
- div_zero  output  1  last divide had b=0; cleared at the next accepted start.
- hi  output  WIDTH  HI register (multiply upper product / divide remainder).
- lo  output  WIDTH  LO register (multiply lower product / divide quotient).

Behaviour:
- Reset (reset=0, any time, including mid-operation):
  - state=IDLE; busy, done, div_zero = 0; hi, lo = 0; counter = 0.
  - An in-flight operation is discarded. There is no partial HI/LO update.
- States: IDLE, RUN, DZ.
  - IDLE -> RUN: start=1 at edge t0, op a multiply or b!=0.
  - IDLE -> DZ: start=1 at t0, op a divide and b=0.
  - RUN -> IDLE after the 32nd iteration.
  - DZ -> IDLE after one cycle.
- At t0:
  - Latch operands as magnitudes; for signed ops, take the two's-complement absolute value and latch the sign bits.
  - Clear the counter and div_zero. busy=1 from t0.
- RUN:
  - One iteration per edge, t1..t32.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per edge.
  - HI/LO are not modified during RUN.
- At t32:
  - Apply sign correction.
    - Signed multiply: negate the 64-bit product if the signs differ.
    - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of a.
  - Write HI/LO. busy=0 and done=1 for the cycle following t32. Result latency is 32 cycles after acceptance.
- DZ: at t1 write hi=a (unmodified), lo=all ones; div_zero=1; done=1 for one cycle; busy=0.
- Handshake:
  - done and busy are never both 1.
  - start with busy=1 is ignored; no queueing.
  - start may be accepted in the same cycle done=1 (back-to-back operations).
- Contention: start=1 together with hi_we/lo_we in IDLE means start wins and the writes are dropped.
- mthi/mtlo:
  - Takes effect at the next edge.
  - hi_we and lo_we may both be asserted.
  - Does not pulse done.
- Arithmetic:
  - All internal sums use WIDTH+1 bits; no overflow flag.
  - MIN_INT / -1 yields lo=0x80000000, hi=0.
- The counter saturates at WIDTH and never wraps while in RUN.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined: op[0] selects signed MULT/DIV with the sign correction above.
- Undefined:
  - op[0] is ignored and all operations are unsigned.
  - The sign-latch and negation logic is not synthesized.
  - Timing and handshake are unchanged.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 32 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- DIVU a=100, b=7 -> after 32 cycles lo=0x0000000E, hi=0x00000002, div_zero=0.
- DIV a=0xFFFFFFF9 (-7), b=2, macro on -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Same stimulus, macro off -> lo=0x7FFFFFFC, hi=0x00000001.
- DIVU a=0x1234, b=0 -> done one cycle after start; hi=0x00001234, lo=0xFFFFFFFF, div_zero=1. A following MULTU 3*5 clears div_zero; lo=15, hi=0.
- Ordered sequence:
  1. MULTU 6*7 running; at cycle 10 pulse start with DIVU 9/3 -> ignored; result lo=42, hi=0.
  2. hi_we=1, wdata=0xA5A5A5A5 while busy -> ignored.
  3. Same hi_we write in IDLE -> hi=0xA5A5A5A5.
- Start MULTU 2*3; drive reset=0 at cycle 15 asynchronously -> busy, done, hi, lo = 0 before the next edge. After release, the next start completes normally in 32 cycles.
